tinyloader: RTL

Byte-stream program loader for the tinycpu system, and the writer side of the CPU's instruction/data RAM. It accepts a framed image (word count, 16-bit words, XOR checksum) over a valid/ready byte interface and writes the words into the RAM write port from address 0 upward. While loading it holds the CPU stopped. It pulses the CPU `run` input only when the checksum matches.

---
 rtl/tinyloader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tinyloader.sv
// -----------------------------------------------------------------------------
// tinyloader
//
// Byte-stream program loader for the tinycpu system. Receives a framed image
//   count_hi, count_lo, N x (word_hi, word_lo), checksum
// over a valid/ready byte interface. Each word goes to the RAM write port,
// starting at address 0. The checksum byte is the XOR of every earlier byte in
// the frame. The CPU is held while a load runs. The CPU gets a one-cycle run
// pulse only when the checksum matches.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : asynchronous, active-low reset
//   start     : begin a load (sampled only in IDLE, DONE and ERR)
//   rx_valid  : source has a byte available
//   rx_data   : byte value
//   rx_ready  : loader can accept a byte (decoded from state, registered)
//   mem_we    : RAM write strobe
//   mem_addr  : RAM write address (also the running address counter)
//   mem_d     : RAM write data (also the word assembly register)
//   cpu_hold  : keeps the CPU stopped while high
//   cpu_run   : one-cycle start pulse to the CPU
//   busy      : a load is in progress
//   done      : last load succeeded (sticky until the next start)
//   err       : last load failed (sticky until the next start)
//
// All outputs are registers. Each is loaded from the next-state decode, so an
// output always agrees with the state it belongs to. Nothing combinational
// runs from rx_valid to rx_ready.
// -----------------------------------------------------------------------------
module tinyloader #(
  parameter int AW = 12,
  parameter int DW = 16   // fixed at 16 by the frame format
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          cpu_hold,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNTH,
    S_CNTL,
    S_DATH,
    S_DATL,
    S_WR,
    S_CSUM,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [7:0]  cnt_hi;     // count high byte, held until the low byte arrives
  logic [7:0]  csum;       // running XOR of all accepted header/data bytes
  logic [15:0] remaining;  // words still to be written

  logic        xfer;
  logic [15:0] count_full;
  logic        count_too_big;
  logic        last_word;

  // A byte moves only when the source offers one and the registered ready is
  // high. Ready is high only in the byte-receiving states.
  assign xfer       = rx_valid && rx_ready;
  assign count_full = {cnt_hi, rx_data};

  // The image may fill the whole RAM (N = 2^AW) but no more. The compare is
  // done in 32 bits, so N = 2^AW is still representable when AW = 16.
  assign count_too_big = (32'(count_full) > (32'd1 << AW));
  assign last_word     = (remaining == 16'd1);

  // Next-state decode
  // NOTE: every signal written in an always_comb block gets a default value
  // at the top. A path that skips the assignment would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_n = S_CNTH;
      end
      S_CNTH: begin
        if (xfer) state_n = S_CNTL;
      end
      S_CNTL: begin
        if (xfer) begin
          if (count_too_big)            state_n = S_ERR;
          else if (count_full == 16'd0) state_n = S_CSUM;
          else                          state_n = S_DATH;
        end
      end
      S_DATH: begin
        if (xfer) state_n = S_DATL;
      end
      S_DATL: begin
        if (xfer) state_n = S_WR;
      end
      S_WR: begin
        state_n = last_word ? S_CSUM : S_DATH;
      end
      S_CSUM: begin
        if (xfer) state_n = (rx_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        state_n = S_DONE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  // NOTE: every register in this block uses a non-blocking assignment (<=).
  // Then all right-hand sides see values from before the edge, whatever order
  // the statements are written in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt_hi    <= '0;
      csum      <= '0;
      remaining <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_d     <= '0;
      cpu_hold  <= 1'b0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;

      // Outputs follow the state being entered, so each one is valid in the
      // same cycle as that state. done and err are sticky only in the sense
      // that DONE and ERR are held until the next start. Leaving either state
      // clears the flag on the same edge that raises busy.
      rx_ready <= (state_n inside {S_CNTH, S_CNTL, S_DATH, S_DATL, S_CSUM});
      mem_we   <= (state_n == S_WR);
      cpu_run  <= (state_n == S_RUN);
      busy     <= (state_n inside {S_CNTH, S_CNTL, S_DATH, S_DATL, S_WR,
                                   S_CSUM, S_RUN});
      // On a failed load the hold stays up, so a partial image is never run.
      cpu_hold <= (state_n inside {S_CNTH, S_CNTL, S_DATH, S_DATL, S_WR,
                                   S_CSUM, S_ERR});
      done     <= (state_n == S_DONE);
      err      <= (state_n == S_ERR);

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            csum     <= '0;
            mem_addr <= '0;
          end
        end
        S_CNTH: begin
          if (xfer) begin
            cnt_hi <= rx_data;
            csum   <= csum ^ rx_data;
          end
        end
        S_CNTL: begin
          if (xfer) begin
            remaining <= count_full;
            csum      <= csum ^ rx_data;
          end
        end
        // mem_d doubles as the word assembly register. Its value only matters
        // while mem_we is high, and both halves are complete by then.
        S_DATH: begin
          if (xfer) begin
            mem_d <= {rx_data, mem_d[7:0]};
            csum  <= csum ^ rx_data;
          end
        end
        S_DATL: begin
          if (xfer) begin
            mem_d <= {mem_d[15:8], rx_data};
            csum  <= csum ^ rx_data;
          end
        end
        S_WR: begin
          // The address is AW bits wide. After a full 2^AW-word image it wraps
          // to 0, and no extra write happens.
          mem_addr  <= mem_addr + 1'b1;
          remaining <= remaining - 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
